// File: rtl/axi_wr_mem_bridge.sv
// ---------------------------------------------------------------------------
// axi_wr_mem_bridge
// Accepts one AXI write burst at a time and turns each W beat into a
// single-cycle write on a simple byte-addressed memory port. After the last
// beat it returns one B response, then goes back to waiting for the next AW.
//
// Ports
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   axi_aw*             : write address channel (lock/cache/prot unused)
//   axi_w*              : write data channel
//   axi_b*              : write response channel
//   mem_we              : one-cycle write strobe, one per accepted W beat
//   mem_addr            : byte address of the beat being written
//   mem_wdata/mem_wstrb : beat data and byte enables as received
// ---------------------------------------------------------------------------
module axi_wr_mem_bridge #(
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   axi_awid,
  input  logic [ADDR_WIDTH-1:0] axi_awaddr,
  input  logic [7:0]            axi_awlen,
  input  logic [2:0]            axi_awsize,
  input  logic [1:0]            axi_awburst,
  input  logic                  axi_awlock,
  input  logic [3:0]            axi_awcache,
  input  logic [2:0]            axi_awprot,
  input  logic                  axi_awvalid,
  output logic                  axi_awready,
  input  logic [DATA_WIDTH-1:0] axi_wdata,
  input  logic [STRB_WIDTH-1:0] axi_wstrb,
  input  logic                  axi_wlast,
  input  logic                  axi_wvalid,
  output logic                  axi_wready,
  output logic [ID_WIDTH-1:0]   axi_bid,
  output logic [1:0]            axi_bresp,
  output logic                  axi_bvalid,
  input  logic                  axi_bready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [STRB_WIDTH-1:0] mem_wstrb
);

  localparam int SIZE_MAX = $clog2(STRB_WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [7:0]            beat_q, beat_d;
  logic                  err_q, err_d;
  logic                  bad_q, bad_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [STRB_WIDTH-1:0] mem_wstrb_q, mem_wstrb_d;

  logic                  aw_hs, w_hs, b_hs, last_beat, aw_bad, wrap_len_ok;
  logic [ADDR_WIDTH-1:0] step, wrap_mask, incr_addr, next_addr;

  // Sideband attributes have no meaning for a flat memory.
  logic unused_aw_sideband;
  assign unused_aw_sideband = ^{axi_awlock, axi_awcache, axi_awprot};

  // Every output is forced to its idle value while reset is held, even in the
  // first reset cycle before the registers have actually cleared.
  assign axi_awready = (state_q == S_IDLE) && !rst;
  assign axi_wready  = (state_q == S_DATA) && !rst;
  assign axi_bvalid  = (state_q == S_RESP) && !rst;
  assign axi_bid     = axi_bvalid ? id_q : '0;
  assign axi_bresp   = (axi_bvalid && (err_q || bad_q)) ? 2'b10 : 2'b00;
  assign mem_we      = mem_we_q && !rst;
  assign mem_addr    = rst ? '0 : mem_addr_q;
  assign mem_wdata   = rst ? '0 : mem_wdata_q;
  assign mem_wstrb   = rst ? '0 : mem_wstrb_q;

  assign aw_hs     = axi_awvalid && axi_awready;
  assign w_hs      = axi_wvalid && axi_wready;
  assign b_hs      = axi_bvalid && axi_bready;
  assign last_beat = (beat_q == len_q);

  // A burst that cannot be addressed sensibly is still drained beat by beat,
  // but none of its beats reach memory and it ends in SLVERR.
  always_comb begin
    wrap_len_ok = (axi_awlen == 8'd1) || (axi_awlen == 8'd3) ||
                  (axi_awlen == 8'd7) || (axi_awlen == 8'd15);
    aw_bad = (axi_awburst == 2'b11) ||
             (int'(axi_awsize) > SIZE_MAX) ||
             ((axi_awburst == 2'b10) && !wrap_len_ok);
  end

  // WRAP keeps the bits above the block size and lets only the offset
  // inside the (len+1)<<size block advance and roll over.
  always_comb begin
    step      = ADDR_WIDTH'(1) << size_q;
    wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
    incr_addr = addr_q + step;
    case (burst_q)
      2'b01:   next_addr = incr_addr;
      2'b10:   next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = addr_q;
    endcase
  end

  // Burst sequencing: capture on AW, one memory write per W beat, then hold
  // the response until the master takes it.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    beat_d      = beat_q;
    err_d       = err_q;
    bad_d       = bad_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    case (state_q)
      S_IDLE: begin
        if (aw_hs) begin
          id_d    = axi_awid;
          addr_d  = axi_awaddr;
          len_d   = axi_awlen;
          size_d  = axi_awsize;
          burst_d = axi_awburst;
          beat_d  = 8'd0;
          err_d   = 1'b0;
          bad_d   = aw_bad;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_hs) begin
          mem_we_d    = !bad_q;
          mem_addr_d  = addr_q;
          mem_wdata_d = axi_wdata;
          mem_wstrb_d = axi_wstrb;
          addr_d      = next_addr;
          beat_d      = beat_q + 8'd1;
          if (axi_wlast != last_beat) begin
            err_d = 1'b1;
          end
          if (last_beat) begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (b_hs) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      bad_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      bad_q       <= bad_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

endmodule

// File: tb/tb_axi_wr_mem_bridge.sv
// ---------------------------------------------------------------------------
// tb_axi_wr_mem_bridge
// Drives AXI write bursts into the bridge. Each W beat pushes its expected
// memory write onto a queue that a negedge monitor pops whenever mem_we
// fires; each burst pushes its expected B response, popped when bvalid shows.
// ---------------------------------------------------------------------------
module tb_axi_wr_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  axi_awid;
  logic [15:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_awlock;
  logic [3:0]  axi_awcache;
  logic [2:0]  axi_awprot;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [63:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [7:0]  axi_bid;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;

  typedef struct {
    logic [15:0] a;
    logic [63:0] d;
    logic [7:0]  s;
  } wr_t;

  typedef struct {
    logic [7:0] id;
    logic [1:0] resp;
  } b_t;

  wr_t wq[$];
  b_t  bq[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  axi_wr_mem_bridge dut (
    .clk(clk), .rst(rst),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(axi_awlock),
    .axi_awcache(axi_awcache), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Reference beat address, computed from offsets rather than masks.
  function automatic logic [15:0] modelAddr(input int start, input int len,
                                            input int size, input logic [1:0] burst,
                                            input int i);
    int step, blk, base, a;
    step = 1 << size;
    case (burst)
      2'b01: a = (start + i * step) & 32'hFFFF;
      2'b10: begin
        blk  = (len + 1) * step;
        base = start - (start % blk);
        a    = base + ((start - base + i * step) % blk);
      end
      default: a = start;
    endcase
    return 16'(a);
  endfunction

  // Memory-side monitor: every mem_we must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we) begin
      if (wq.size() == 0) begin
        checkOutput("unexp_we", {48'd0, mem_addr}, 64'hDEAD);
      end else begin
        wr_t e;
        e = wq.pop_front();
        checkOutput("mem_addr", mem_addr, e.a);
        checkOutput("mem_wdata", mem_wdata, e.d);
        checkOutput("mem_wstrb", mem_wstrb, e.s);
      end
    end
    if (axi_awready && axi_wready) begin
      checkOutput("aw_w_excl", 1, 0);
    end
  end

  // One burst. wlastIdx picks the beat carrying wlast; abortAfter >= 0 stops
  // after that many beats and pulses reset instead of finishing the burst.
  task automatic applyStimulus(input logic [7:0] id, input logic [15:0] addr,
                               input int len, input int size, input logic [1:0] burst,
                               input int wlastIdx, input logic [7:0] strb,
                               input int stall, input int abortAfter);
    bit bad, lerr;
    int cnt, nbeats;
    bad  = (burst == 2'b11) || (size > 3) ||
           ((burst == 2'b10) && !(len inside {1, 3, 7, 15}));
    lerr = (wlastIdx != len);
    nbeats = (abortAfter >= 0) ? abortAfter : len + 1;

    @(negedge clk);
    axi_awid = id; axi_awaddr = addr; axi_awlen = 8'(len);
    axi_awsize = 3'(size); axi_awburst = burst;
    axi_awlock = 1'b1; axi_awcache = 4'hF; axi_awprot = 3'h7;
    axi_awvalid = 1'b1;
    cnt = 0;
    while (!axi_awready && cnt < 50) begin @(negedge clk); cnt++; end
    if (cnt >= 50) checkOutput("tmo_aw", 0, 1);
    @(negedge clk);
    axi_awvalid = 1'b0;
    checkOutput("awready_busy", axi_awready, 0);

    for (int i = 0; i < nbeats; i++) begin
      axi_wdata  = {$urandom, $urandom};
      axi_wstrb  = strb;
      axi_wlast  = (i == wlastIdx);
      axi_wvalid = 1'b1;
      cnt = 0;
      while (!axi_wready && cnt < 50) begin @(negedge clk); cnt++; end
      if (cnt >= 50) checkOutput("tmo_w", 0, 1);
      if (!bad) wq.push_back('{a: modelAddr(addr, len, size, burst, i), d: axi_wdata, s: strb});
      @(negedge clk);
    end
    axi_wvalid = 1'b0;
    axi_wlast  = 1'b0;

    if (abortAfter >= 0) begin
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("rst_awready", axi_awready, 0);
      checkOutput("rst_wready", axi_wready, 0);
      checkOutput("rst_bvalid", axi_bvalid, 0);
      checkOutput("rst_bid", axi_bid, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("post_rst_awready", axi_awready, 1);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        checkOutput("post_rst_bvalid", axi_bvalid, 0);
      end
      checkOutput("wq_empty_abort", wq.size(), 0);
      return;
    end

    checkOutput("wready_off", axi_wready, 0);
    bq.push_back('{id: id, resp: (bad || lerr) ? 2'b10 : 2'b00});
    cnt = 0;
    while (!axi_bvalid && cnt < 50) begin @(negedge clk); cnt++; end
    if (cnt >= 50) checkOutput("tmo_b", 0, 1);
    begin
      b_t e;
      e = bq.pop_front();
      checkOutput("bid", axi_bid, e.id);
      checkOutput("bresp", axi_bresp, e.resp);
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        checkOutput("hold_bvalid", axi_bvalid, 1);
        checkOutput("hold_bid", axi_bid, e.id);
        checkOutput("hold_bresp", axi_bresp, e.resp);
        checkOutput("hold_awready", axi_awready, 0);
      end
    end
    axi_bready = 1'b1;
    @(negedge clk);
    axi_bready = 1'b0;
    checkOutput("b_done", axi_bvalid, 0);
    checkOutput("idle_awready", axi_awready, 1);
    checkOutput("wq_empty", wq.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    axi_awid = '0; axi_awaddr = '0; axi_awlen = '0; axi_awsize = '0; axi_awburst = '0;
    axi_awlock = 1'b0; axi_awcache = '0; axi_awprot = '0; axi_awvalid = 1'b0;
    axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0;
    axi_bready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_awready", axi_awready, 0);
    checkOutput("reset_wready", axi_wready, 0);
    checkOutput("reset_bvalid", axi_bvalid, 0);
    checkOutput("reset_mem_we", mem_we, 0);
    checkOutput("reset_bresp", axi_bresp, 0);
    checkOutput("reset_mem_wstrb", mem_wstrb, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("first_awready", axi_awready, 1);

    applyStimulus(8'h5A, 16'h0100, 3, 3, 2'b01, 3, 8'hFF, 0, -1);
    applyStimulus(8'h11, 16'h0118, 3, 3, 2'b10, 3, 8'hFF, 0, -1);
    applyStimulus(8'h22, 16'h0200, 1, 3, 2'b11, 1, 8'hFF, 0, -1);
    applyStimulus(8'h33, 16'h0300, 3, 3, 2'b01, 1, 8'hFF, 5, -1);
    applyStimulus(8'h44, 16'h0400, 7, 3, 2'b01, 7, 8'hFF, 0, 2);
    applyStimulus(8'h55, 16'h0040, 1, 3, 2'b00, 1, 8'hFF, 0, -1);
    applyStimulus(8'h66, 16'hFFF8, 1, 3, 2'b01, 1, 8'h0F, 0, -1);
    applyStimulus(8'h77, 16'h0024, 2, 2, 2'b10, 2, 8'hFF, 0, -1);
    applyStimulus(8'h78, 16'h0000, 0, 4, 2'b01, 0, 8'hFF, 0, -1);
    applyStimulus(8'h79, 16'h0034, 7, 2, 2'b10, 7, 8'hA5, 2, -1);
    applyStimulus(8'h7A, 16'h0500, 2, 3, 2'b01, 5, 8'hFF, 0, -1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_wr_mem_bridge.md
AXI_WR_MEM_BRIDGE -- requirements
Module: axi_wr_mem_bridge

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 8, meaning AXI ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, meaning byte address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, meaning W data width.
REQ-004 SHALL have parameter STRB_WIDTH, default 8, meaning DATA_WIDTH/8.
REQ-005 SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock for all state.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have the AW receiver ports with the usual widths:
- inputs: axi_awid, axi_awaddr, axi_awlen[7:0], axi_awsize[2:0], axi_awburst[1:0], axi_awlock, axi_awcache[3:0], axi_awprot[2:0], axi_awvalid.
- output: axi_awready.
REQ-008 SHALL have the W receiver ports:
- inputs: axi_wdata[DATA_WIDTH], axi_wstrb[STRB_WIDTH], axi_wlast, axi_wvalid.
- output: axi_wready.
REQ-009 SHALL have the B sender ports:
- outputs: axi_bid[ID_WIDTH], axi_bresp[1:0], axi_bvalid.
- input: axi_bready.
REQ-010 SHALL have the memory write port, all outputs:
- mem_we  1  write strobe.
- mem_addr  ADDR_WIDTH  beat byte address.
- mem_wdata  DATA_WIDTH  write data.
- mem_wstrb  STRB_WIDTH  byte enables.

Function
REQ-011 SHALL implement FSM IDLE -> DATA -> RESP -> IDLE, one burst at a time.
REQ-012 In IDLE, SHALL assert axi_awready=1; axi_wready=0, axi_bvalid=0.
REQ-013 On an AW handshake, SHALL capture id/addr/len/size/burst, clear beat counter and error flag, and go to DATA.
REQ-014 SHALL ignore axi_awlock, axi_awcache and axi_awprot.
REQ-015 In DATA, SHALL assert axi_wready=1 and axi_awready=0.
REQ-016 For each W handshake, SHALL drive mem_we=1 the following cycle, with mem_addr = current beat address and wdata/wstrb as received; mem_we=0 in all other cycles.
REQ-017 SHALL compute the next beat address as follows:
- FIXED (2'b00): unchanged.
- INCR (2'b01): +(1<<size), modulo 2^ADDR_WIDTH.
- WRAP (2'b10): +(1<<size) wrapped within the aligned block of (len+1)<<size bytes.
REQ-018 SHALL flag the burst as an error, suppress all mem_we for it, and still accept exactly len+1 beats, when any of these holds:
- burst==2'b11;
- size > log2(STRB_WIDTH);
- WRAP with len not in {1,3,7,15}.
REQ-019 SHALL flag an error when axi_wlast=1 on a non-final beat or axi_wlast=0 on the final beat; writes are still performed unless REQ-018 also applies.
REQ-020 After the (len+1)th W handshake, SHALL deassert axi_wready the next cycle and go to RESP.
REQ-021 In RESP, SHALL assert axi_bvalid=1 with axi_bid=captured id and axi_bresp = 2'b10 (SLVERR) if the error flag is set, else 2'b00.
REQ-022 SHALL hold all B outputs stable until axi_bready=1, then return to IDLE the next cycle.
REQ-023 SHALL accept no new AW until it returns to IDLE (no AW/B overlap).
REQ-024 SHALL never assert axi_awready and axi_wready in the same cycle.

Reset
REQ-025 While rst=1, SHALL hold FSM=IDLE and drive axi_awready=0, axi_wready=0, axi_bvalid=0, mem_we=0, axi_bid=0, axi_bresp=0, mem_addr/wdata/wstrb=0.
REQ-026 SHALL discard any in-flight burst on reset, with no further mem_we or B for it, and assert axi_awready=1 in the first cycle after rst deasserts.

Verification
REQ-027 INCR: awaddr=0x0100, len=3, size=3, id=0x5A, 4 beats with wlast on beat 4 -> mem_we at 0x0100, 0x0108, 0x0110, 0x0118; bid=0x5A, bresp=00.
REQ-028 WRAP: awaddr=0x0118, len=3, size=3 -> mem_addr 0x0118, 0x0100, 0x0108, 0x0110; bresp=00.
REQ-029 Reserved burst=2'b11, len=1 -> 2 beats accepted, mem_we never asserted, bresp=10.
REQ-030 INCR len=3 with wlast on beat 2 -> 4 writes performed, bresp=10; with axi_bready=0 for 5 cycles, bvalid/bid/bresp held stable and no awready.
REQ-031 rst=1 for 1 cycle after beat 2 of a len=7 burst -> no further mem_we, no bvalid; next burst (FIXED, addr 0x0040, len=1) writes 0x0040 twice with bresp=00.
REQ-032 W beats with wstrb=0x0F and INCR wrap-around from awaddr=0xFFF8, size=3, len=1 -> mem_addr 0xFFF8 then 0x0000, mem_wstrb=0x0F on both.
